// File: rtl/overlay_deadlock_report_arbiter.sv
// Deadlock report arbiter: persistence-filters NUM_MON monitor block flags and shares one
// valid/ready report channel round-robin. Define DEADLOCK_RPT_TIMESTAMP_EN to add rpt_time.
module overlay_deadlock_report_arbiter #(
   parameter int NUM_MON = 4,
   parameter int IDX_W   = 2,
   parameter int INFO_W  = 4,
   parameter int PERSIST = 16,
   parameter int CNT_W   = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_MON-1:0]        mon_block,
   input  logic [NUM_MON*INFO_W-1:0] mon_info,
   input  logic                      rearm,
   output logic                      rpt_valid,
   input  logic                      rpt_ready,
   output logic [IDX_W-1:0]          rpt_idx,
   output logic [INFO_W-1:0]         rpt_info,
`ifdef DEADLOCK_RPT_TIMESTAMP_EN
   output logic [31:0]               rpt_time,
`endif
   output logic                      any_deadlock
);

   localparam int SEL_W = (NUM_MON > 1) ? $clog2(NUM_MON) : 1;
   localparam logic [CNT_W-1:0] CONF_CNT = CNT_W'(PERSIST - 1);
   localparam logic [CNT_W-1:0] SAT_CNT  = CNT_W'(PERSIST);

   typedef enum logic {
      S_EMPTY,
      S_FULL
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt      [NUM_MON];
   logic [INFO_W-1:0]   info_lat [NUM_MON];
   logic [NUM_MON-1:0]  pending;
   logic [NUM_MON-1:0]  reported;
   logic [IDX_W-1:0]    ptr;

   logic                hs;
   logic                can_load;
   logic                load;
   logic                win_found;
   logic [IDX_W-1:0]    win_idx;
   logic [IDX_W-1:0]    next_idx;
   logic [IDX_W-1:0]    base;
   logic [NUM_MON-1:0]  confirm;
   logic [NUM_MON-1:0]  in_reg;
   logic [NUM_MON-1:0]  load_hit;
   logic [NUM_MON-1:0]  hs_hit;

`ifdef DEADLOCK_RPT_TIMESTAMP_EN
   logic [31:0]         cycle_cnt;
   logic [31:0]         time_lat [NUM_MON];
`endif

   function automatic int unsigned wrap_idx(input int unsigned s);
      return (s >= NUM_MON) ? s - NUM_MON : s;
   endfunction

   assign rpt_valid = (state == S_FULL);

   always_comb begin
      hs       = rpt_valid & rpt_ready;
      next_idx = (rpt_idx == IDX_W'(NUM_MON - 1)) ? '0 : rpt_idx + 1'b1;
      base     = hs ? next_idx : ptr;
      can_load = ~rpt_valid | hs;

      // A saturated counter re-confirms after rearm; the monitor held in the output
      // register is excluded so a held block cannot queue a duplicate of itself.
      for (int unsigned i = 0; i < NUM_MON; i++) begin
         in_reg[i]  = rpt_valid && (rpt_idx == IDX_W'(i));
         hs_hit[i]  = hs && (rpt_idx == IDX_W'(i));
         confirm[i] = mon_block[i] && (cnt[i] >= CONF_CNT) && !pending[i]
                      && !(reported[i] && !rearm) && !in_reg[i];
      end

      win_found = 1'b0;
      win_idx   = '0;
      for (int unsigned k = 0; k < NUM_MON; k++) begin
         if (!win_found && pending[SEL_W'(wrap_idx(32'(base) + k))]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(wrap_idx(32'(base) + k));
         end
      end

      load = can_load & win_found;
      for (int unsigned i = 0; i < NUM_MON; i++) begin
         load_hit[i] = load && (win_idx == IDX_W'(i));
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= S_EMPTY;
         ptr          <= '0;
         rpt_idx      <= '0;
         rpt_info     <= '0;
         pending      <= '0;
         reported     <= '0;
         any_deadlock <= 1'b0;
         for (int unsigned i = 0; i < NUM_MON; i++) begin
            cnt[i]      <= '0;
            info_lat[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_MON; i++) begin
            if (!mon_block[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] < SAT_CNT) begin
               cnt[i] <= cnt[i] + 1'b1;
            end
            if (confirm[i]) begin
               info_lat[i] <= mon_info[i*INFO_W +: INFO_W];
            end
         end

         pending      <= (pending & mon_block & ~load_hit) | confirm;
         reported     <= (reported | hs_hit) & mon_block & {NUM_MON{~rearm}};
         any_deadlock <= |(pending | reported);

         if (hs) begin
            ptr <= next_idx;
         end

         if (load) begin
            state    <= S_FULL;
            rpt_idx  <= win_idx;
            rpt_info <= info_lat[SEL_W'(win_idx)];
         end else if (hs) begin
            state <= S_EMPTY;
         end
      end
   end

`ifdef DEADLOCK_RPT_TIMESTAMP_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         cycle_cnt <= '0;
         rpt_time  <= '0;
         for (int unsigned i = 0; i < NUM_MON; i++) begin
            time_lat[i] <= '0;
         end
      end else begin
         cycle_cnt <= cycle_cnt + 1'b1;
         for (int unsigned i = 0; i < NUM_MON; i++) begin
            if (confirm[i]) begin
               time_lat[i] <= cycle_cnt;
            end
         end
         if (load) begin
            rpt_time <= time_lat[SEL_W'(win_idx)];
         end
      end
   end
`endif

endmodule

// File: tb/tb_overlay_deadlock_report_arbiter.sv
// Bench for overlay_deadlock_report_arbiter: directed episodes then random traffic,
// every cycle compared against a streak/queue-level reference model.
module tb_overlay_deadlock_report_arbiter;

   localparam int N   = 4;
   localparam int IW  = 2;
   localparam int INF = 4;
   localparam int PER = 16;
   localparam int CW  = 8;

   logic              clock = 1'b0;
   logic              reset;
   logic [N-1:0]      mon_block;
   logic [N*INF-1:0]  mon_info;
   logic              rearm;
   logic              rpt_valid;
   logic              rpt_ready;
   logic [IW-1:0]     rpt_idx;
   logic [INF-1:0]    rpt_info;
   logic              any_deadlock;
`ifdef DEADLOCK_RPT_TIMESTAMP_EN
   logic [31:0]       rpt_time;
`endif

   overlay_deadlock_report_arbiter #(
      .NUM_MON (N),
      .IDX_W   (IW),
      .INFO_W  (INF),
      .PERSIST (PER),
      .CNT_W   (CW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .mon_block    (mon_block),
      .mon_info     (mon_info),
      .rearm        (rearm),
      .rpt_valid    (rpt_valid),
      .rpt_ready    (rpt_ready),
      .rpt_idx      (rpt_idx),
      .rpt_info     (rpt_info),
`ifdef DEADLOCK_RPT_TIMESTAMP_EN
      .rpt_time     (rpt_time),
`endif
      .any_deadlock (any_deadlock)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // reference model state
   int          m_streak [N];
   bit          m_pend   [N];
   bit          m_rep    [N];
   int          m_inf    [N];
   int unsigned m_tlat   [N];
   bit          m_valid;
   int          m_idx;
   int          m_info;
   int unsigned m_time;
   int          m_ptr;
   bit          m_any;
   int unsigned m_cycle;

   int  nvalid, first, vidx, vinfo;
   bit  saw, anys;
   int  obsq [$];
   int  exp_seq [8] = '{0, 0, 0, 0, 0, 0, 2, 3};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      bit hs;
      int base;
      int hidx;
      int lj;
      bit cf [N];
      bit new_any;
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            m_streak[i] = 0; m_pend[i] = 0; m_rep[i] = 0; m_inf[i] = 0; m_tlat[i] = 0;
         end
         m_valid = 0; m_idx = 0; m_info = 0; m_time = 0; m_ptr = 0; m_any = 0; m_cycle = 0;
         return;
      end
      hs   = m_valid && rpt_ready;
      hidx = m_idx;
      base = hs ? (m_idx + 1) % N : m_ptr;
      for (int i = 0; i < N; i++) begin
         m_streak[i] = mon_block[i] ? m_streak[i] + 1 : 0;
         cf[i] = mon_block[i] && (m_streak[i] >= PER) && !m_pend[i]
                 && !(m_rep[i] && !rearm) && !(m_valid && m_idx == i);
      end
      new_any = 0;
      for (int i = 0; i < N; i++) new_any |= m_pend[i] | m_rep[i];
      lj = -1;
      if (!m_valid || hs) begin
         for (int k = 0; k < N; k++) begin
            if (lj < 0 && m_pend[(base + k) % N]) lj = (base + k) % N;
         end
      end
      if (lj >= 0) begin
         m_valid = 1; m_idx = lj; m_info = m_inf[lj]; m_time = m_tlat[lj];
      end else if (hs) begin
         m_valid = 0;
      end
      m_ptr = base;
      for (int i = 0; i < N; i++) begin
         if (i == lj) m_pend[i] = 0;
         if (!mon_block[i]) m_pend[i] = 0;
         if (cf[i]) m_pend[i] = 1;
         if (hs && hidx == i) m_rep[i] = 1;
         if (rearm || !mon_block[i]) m_rep[i] = 0;
         if (cf[i]) begin
            m_inf[i]  = int'(mon_info[i*INF +: INF]);
            m_tlat[i] = m_cycle;
         end
      end
      m_any = new_any;
      m_cycle++;
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
      chk("valid", rpt_valid, m_valid);
      chk("any", any_deadlock, m_any);
      chk("idx", rpt_idx, m_idx);
      chk("info", rpt_info, m_info);
`ifdef DEADLOCK_RPT_TIMESTAMP_EN
      chk("time", rpt_time, m_time);
`endif
   endtask

   initial begin
      reset = 1; rearm = 0; rpt_ready = 0; mon_block = '0; mon_info = '0;
      repeat (2) tick();
      chk("rst_valid", rpt_valid, 0);
      chk("rst_any", any_deadlock, 0);
      chk("rst_idx", rpt_idx, 0);
      chk("rst_info", rpt_info, 0);
      reset = 0;

      // transient stall one cycle short of confirmation
      mon_block = 4'b0100; saw = 0; anys = 0;
      repeat (15) begin tick(); saw |= rpt_valid; anys |= any_deadlock; end
      mon_block = '0;
      repeat (4) begin tick(); saw |= rpt_valid; anys |= any_deadlock; end
      chk("t1_no_report", saw, 0);
      chk("t1_any", anys, 0);

      // single held stall, ready high
      mon_info = 16'h00E0; rpt_ready = 1; mon_block = 4'b0010;
      nvalid = 0; first = 0; vidx = -1; vinfo = -1;
      for (int n = 1; n <= 30; n++) begin
         tick();
         if (rpt_valid) begin
            nvalid++;
            if (first == 0) begin first = n; vidx = rpt_idx; vinfo = rpt_info; end
         end
      end
      chk("t2_count", nvalid, 1);
      chk("t2_cycle", first, 17);
      chk("t2_idx", vidx, 1);
      chk("t2_info", vinfo, 4'hE);
      mon_block = '0;
      repeat (3) tick();

      // simultaneous confirms with back-pressure
      reset = 1; tick(); reset = 0;
      rpt_ready = 0; mon_block = 4'b1101; nvalid = 0;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (rpt_valid) begin
            obsq.push_back(int'(rpt_idx));
            nvalid++;
            if (nvalid == 6) rpt_ready = 1;
         end
      end
      chk("t3_len", obsq.size(), 8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t3_seq%0d", i), (i < obsq.size()) ? obsq[i] : -1, exp_seq[i]);
      end

      // rearm with block still held re-reports
      mon_block = 4'b1000;
      repeat (3) tick();
      rearm = 1; tick();
      chk("t4_pend_cycle", rpt_valid, 0);
      rearm = 0; tick();
      chk("t4_valid", rpt_valid, 1);
      chk("t4_idx", rpt_idx, 3);
      repeat (4) tick();
      mon_block = '0; repeat (2) tick();
      mon_block = 4'b1000; repeat (10) tick();
      mon_block = '0; rearm = 1; tick(); rearm = 0;
      saw = 0;
      repeat (20) begin tick(); saw |= rpt_valid; end
      chk("t4_no_report", saw, 0);

      // report held after its block drops
      rpt_ready = 0; mon_block = 4'b0010;
      for (int n = 0; n < 30 && !rpt_valid; n++) tick();
      chk("t5_valid", rpt_valid, 1);
      mon_block = '0;
      repeat (4) begin
         tick();
         chk("t5_held_valid", rpt_valid, 1);
         chk("t5_held_idx", rpt_idx, 1);
      end
      rpt_ready = 1; tick();
      chk("t5_accept", rpt_valid, 0);
      mon_block = 4'b0010; nvalid = 0; vidx = -1;
      repeat (25) begin
         tick();
         if (rpt_valid) begin nvalid++; vidx = rpt_idx; end
      end
      chk("t5_next_count", nvalid, 1);
      chk("t5_next_idx", vidx, 1);
      mon_block = '0; repeat (2) tick();

      // reset drops a presented report
      rpt_ready = 0; mon_block = 4'b0001;
      for (int n = 0; n < 30 && !rpt_valid; n++) tick();
      chk("t6_presented", rpt_valid, 1);
      reset = 1; tick();
      chk("t6_valid", rpt_valid, 0);
      chk("t6_any", any_deadlock, 0);
      reset = 0; mon_block = '0;

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 23) == 0) mon_block[i] = ~mon_block[i];
         end
         mon_info  = N*INF'($urandom);
         rpt_ready = ($urandom_range(0, 2) != 0);
         rearm     = ($urandom_range(0, 59) == 0);
         reset     = ($urandom_range(0, 999) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/overlay_deadlock_report_arbiter.md
Name: overlay_deadlock_report_arbiter

Overview:
Collects block flags and block-info vectors from NUM_MON HLS deadlock monitor instances in the overlay control path. Filters transient stalls with a per-monitor persistence counter. Shares one report channel among the monitors using a round-robin arbiter. Emits one valid/ready report per deadlock episode to the debug/status logic.

Parameters:
NUM_MON, 4, number of monitor instances arbitrated (2..16)
IDX_W, 2, width of report index; must be >= clog2(NUM_MON)
INFO_W, 4, width of each monitor's axis_block_info vector
PERSIST, 16, consecutive block cycles required before a report is raised (1..2^CNT_W-1)
CNT_W, 8, width of persistence counters

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
mon_block  in  NUM_MON  block flag per monitor; bit i = monitor i
mon_info  in  NUM_MON*INFO_W  info per monitor; slice [i*INFO_W +: INFO_W] = monitor i
rearm  in  1  single-cycle pulse; clears all reported flags
rpt_valid  out  1  report available
rpt_ready  in  1  consumer accepts report
rpt_idx  out  IDX_W  index of reporting monitor
rpt_info  out  INFO_W  info captured when the deadlock was confirmed
any_deadlock  out  1  OR over all monitors of (pending | reported)

Behaviour:
- Reset is synchronous, active-high, on clock. Reset clears all counters, pending, reported, the round-robin pointer, rpt_valid, rpt_idx and rpt_info (all 0). any_deadlock is 0 from the cycle after reset is sampled.
- A reset asserted mid-operation drops any presented report; no handshake is required.
- Per monitor i, persistence counter cnt[i]:
  - mon_block[i]=0: cnt <= 0.
  - mon_block[i]=1: cnt <= cnt+1, saturating at PERSIST.
- Confirm event for monitor i: mon_block[i]=1, cnt[i]==PERSIST-1, pending[i]=0, reported[i]=0. The event sets pending[i] and latches info[i] from the mon_info slice in that cycle.
  - Net effect: pending rises on the clock edge ending the PERSIST-th consecutive block cycle.
  - PERSIST=1 means pending sets on the first block cycle.
- Withdrawal: mon_block[i]=0 while pending[i]=1 and monitor i is not in the output register. This clears pending[i] with no report (stale stall).
- Re-arm:
  - mon_block[i]=0 clears reported[i].
  - rearm=1 clears all reported bits.
  - A rearm arriving in the same cycle as a handshake wins: the handshaken monitor ends with reported=0.
- Output stage, 2 states:
  - EMPTY (rpt_valid=0): if any pending is set, load the winner into rpt_idx/rpt_info, clear its pending, go to FULL. The winner is the first pending index at or after ptr, wrapping modulo NUM_MON.
  - FULL (rpt_valid=1): rpt_idx and rpt_info are held stable until rpt_valid & rpt_ready.
  - On handshake: set reported[rpt_idx] and set ptr <= rpt_idx+1, wrapping to 0 after NUM_MON-1.
  - Same cycle as a handshake: if another pending exists, load it and stay FULL (back-to-back, 1 report/cycle); otherwise go to EMPTY.
  - The winner in that cycle uses the updated pointer (rpt_idx+1).
- A report in the output register is never withdrawn, even if its mon_block deasserts.
- Loading into the output register does not set reported; only the handshake does.
- Latency: confirm event to rpt_valid is 1 cycle when the output stage is empty.
- A confirm event and a load of the same index in one cycle is not possible; pending must be registered first.
- any_deadlock is registered: 1 cycle after any pending/reported bit changes.
- Indices >= NUM_MON are never produced.

Optional Feature:
Macro DEADLOCK_RPT_TIMESTAMP_EN.
- Defined:
  - Adds a 32-bit free-running cycle counter, reset to 0, wrapping at 2^32.
  - Adds output port rpt_time [31:0], the counter value latched at the confirm event and carried with the report.
  - rpt_time resets to 0.
- Undefined: no counter, no rpt_time port; all other behaviour is identical.

Test Plan:
- PERSIST=16, mon_block[2] high for 15 cycles then low -> no rpt_valid; any_deadlock stays 0.
- mon_block[1]=1 held, mon_info slice 1 = 4'hE, rpt_ready=1 -> rpt_valid for exactly one cycle, 17 cycles after block rises (16 to pend + 1 to load); rpt_idx=1, rpt_info=4'hE; no further report while block is held.
- Monitors 0, 2, 3 confirmed in the same cycle, rpt_ready held low 5 cycles then high -> rpt_valid stable with idx 0 for 5 cycles, then idx 0, 2, 3 on consecutive cycles.
- After monitor 3 is reported, assert rearm with mon_block[3] still high -> second report idx 3 one cycle after the pulse; with mon_block[3] dropped before confirm -> no report.
- Report for idx 1 presented with rpt_ready=0, then mon_block[1] drops -> report still held; accepted when rpt_ready=1; next episode reported normally.
- Reset asserted while rpt_valid=1 -> rpt_valid=0, any_deadlock=0 the next cycle; with DEADLOCK_RPT_TIMESTAMP_EN, confirm at counter value 100 gives rpt_time=100.
